// File: rtl/dccm_ctrl.sv
// DCCM responder for the LSU port: scrubs the array to zero after reset, then serves
// fixed-latency reads and single-cycle writes. Optional macro DCCM_WR_FWD_EN selects write-first collisions.
module dccm_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0001_0000,
  parameter int              RD_LAT      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] dccm_raddr,
  input  logic            dccm_rvalid_in,
  output logic [XLEN-1:0] dccm_rdata,
  output logic            dccm_rvalid_out,
  input  logic [XLEN-1:0] dccm_waddr,
  input  logic            dccm_wen,
  input  logic [XLEN-1:0] dccm_wdata,
  output logic            dccm_ready,
  output logic            dccm_err,
  output logic            dccm_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-AW-3:0] BASE_TAG = BASE_ADDR[XLEN-1:AW+2];
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_SCRUB = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_scrub_cnt;
  logic            r_ready;
  logic            r_err;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [RD_LAT-1:0] r_pv;
  logic [XLEN-1:0] r_pd [RD_LAT];

  logic            w_run;
  logic            w_rd_in_range;
  logic            w_wr_in_range;
  logic [AW-1:0]   w_ridx;
  logic [AW-1:0]   w_widx;
  logic            w_rd_acc;
  logic            w_wr_ok;
  logic [XLEN-1:0] w_rd_word;
  logic [XLEN-1:0] w_rd_entry;
  logic            w_err_next;
  logic            w_unused;

  // Requests carry no handshake: a strobe high on a rising edge is one request,
  // and a response is a single dccm_rvalid_out cycle exactly RD_LAT cycles later.
  assign w_run         = (r_state == ST_RUN);
  assign w_rd_in_range = (dccm_raddr[XLEN-1:AW+2] == BASE_TAG);
  assign w_wr_in_range = (dccm_waddr[XLEN-1:AW+2] == BASE_TAG);
  assign w_ridx        = dccm_raddr[AW+1:2];
  assign w_widx        = dccm_waddr[AW+1:2];
  assign w_rd_acc      = w_run & dccm_rvalid_in;
  assign w_wr_ok       = w_run & dccm_wen & w_wr_in_range;
  assign w_unused      = ^{dccm_raddr[1:0], dccm_waddr[1:0]};

`ifdef DCCM_WR_FWD_EN
  assign w_rd_word = (w_wr_ok && (w_widx == w_ridx)) ? dccm_wdata : r_mem[w_ridx];
`else
  assign w_rd_word = r_mem[w_ridx];
`endif

  // Out-of-range reads still answer, with zero data, to keep the response stream in order.
  assign w_rd_entry = (w_rd_acc && w_rd_in_range) ? w_rd_word : '0;
  assign w_err_next = (dccm_rvalid_in & (~w_run | ~w_rd_in_range)) |
                      (dccm_wen       & (~w_run | ~w_wr_in_range));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SCRUB;
      r_scrub_cnt <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err   <= w_err_next;
      r_ready <= (r_state == ST_RUN);
      case (r_state)
        ST_SCRUB: begin
          r_scrub_cnt <= r_scrub_cnt + 1'b1;
          if (r_scrub_cnt == LAST_WORD) r_state <= ST_RUN;
        end
        ST_RUN:   r_state <= ST_RUN;
        default:  r_state <= ST_SCRUB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run) r_mem[r_scrub_cnt] <= '0;
      else if (w_wr_ok) r_mem[w_widx] <= dccm_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pd[i] <= '0;
    end else begin
      r_pv[0] <= w_rd_acc;
      r_pd[0] <= w_rd_entry;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign dccm_rvalid_out = r_pv[RD_LAT-1];
  assign dccm_rdata      = r_pd[RD_LAT-1];
  assign dccm_ready      = r_ready;
  assign dccm_err        = r_err;
  assign dccm_dbg_state  = r_state;

endmodule

// File: doc/dccm_ctrl.md
# dccm_ctrl

Responder side of the LSU-to-DCCM port: owns the data closely coupled memory array and answers the read and write requests issued by the execution unit's load/store unit. It sits beside the core, connected directly to the EXU DCCM port. It provides:
- Fixed-latency read pipeline.
- Single-cycle writes.
- Post-reset zero-scrub state machine.
- Out-of-range detection.

## Interface
Parameters:
- DEPTH_WORDS, 4096, number of XLEN-bit words; power of two, ≥ 16.
- BASE_ADDR, 32'h0001_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- RD_LAT, 1, read latency in cycles from request to rvalid_out; legal 1..4.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- dccm_raddr  in  XLEN  read byte address; bits [1:0] ignored.
- dccm_rvalid_in  in  1  read request strobe, one request per asserted cycle.
- dccm_rdata  out  XLEN  read data, qualified by dccm_rvalid_out.
- dccm_rvalid_out  out  1  read response strobe.
- dccm_waddr  in  XLEN  write byte address; bits [1:0] ignored.
- dccm_wen  in  1  write strobe, full-word write.
- dccm_wdata  in  XLEN  write data.
- dccm_ready  out  1  high once the scrub has finished.
- dccm_err  out  1  one-cycle pulse for an out-of-range or dropped access.

## Operation
- **State machine:** SCRUB → RUN. Reset forces SCRUB.
  - SCRUB: a word counter walks 0..DEPTH_WORDS-1 and writes 0 to one word per cycle.
  - On the cycle the counter reaches DEPTH_WORDS-1, the next state is RUN. dccm_ready rises the following cycle.
- **Range check:** an access is in range when BASE_ADDR ≤ addr < BASE_ADDR + DEPTH_WORDS*4. Index = (addr − BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- **Reads in RUN:** each dccm_rvalid_in cycle enters a RD_LAT-deep valid/data shift pipeline. Back-to-back requests are accepted every cycle with no bubbles. Responses return in request order.
- **Out-of-range read:** still produces a response at the normal latency, with dccm_rdata = 0. dccm_err pulses on the request cycle.
- **Writes in RUN:** an in-range write updates the array at the clock edge of the request cycle. An out-of-range write is dropped and dccm_err pulses.
- **Requests during SCRUB:** dropped. No response is ever produced, dccm_err pulses for each one, and the array is not changed by them.
- **Simultaneous in-range read and write:**
  - Different words: both proceed independently.
  - Same word: collision policy per Configuration.
- **Simultaneous out-of-range read and write:** a single dccm_err pulse.
- dccm_rdata is 0 whenever dccm_rvalid_out is 0.

## Timing
- Reset values: dccm_rvalid_out = 0, dccm_rdata = 0, dccm_ready = 0, dccm_err = 0, scrub counter = 0, all pipeline stages invalid.
- Reset mid-operation: all in-flight reads are discarded, so no dccm_rvalid_out appears after rst. The scrub restarts from word 0.
- Scrub duration: dccm_ready first asserts DEPTH_WORDS + 1 cycles after rst deasserts.
- Read latency: a request at cycle T produces dccm_rvalid_out at T + RD_LAT.
- Write visibility: a write at cycle T is visible to a read issued at T + 1 or later.
- dccm_err is registered and asserts at T + 1 for an offending request at T.
- Throughput: one read plus one write per cycle. There is no backpressure in RUN.

## Configuration
- DCCM_WR_FWD_EN, when defined (write-first): a same-cycle, same-word read returns dccm_wdata. This is implemented by a comparator and a mux at the pipeline entry.
- DCCM_WR_FWD_EN, when undefined (read-first): the same read returns the prior array contents. The comparator and mux are not generated.
- Writes are never affected by this macro.

## Test plan
- Reset scrub: DEPTH_WORDS = 16, deassert rst → dccm_ready = 0 for 16 cycles, then 1 at cycle 17. Reading all 16 words then returns 0.
- Write/read latency: RD_LAT = 2. Write 32'hDEAD_BEEF to BASE_ADDR + 8 at T, read the same address at T + 1 → dccm_rvalid_out at T + 3 with dccm_rdata = 32'hDEAD_BEEF.
- Streaming: 8 back-to-back reads of preloaded words 0..7 (value = index*3) → 8 consecutive rvalid_out cycles with data 0, 3, …, 21 in order.
- Collision: with word 4 = 32'h1111_1111, issue a read and a write of 32'h2222_2222 to word 4 in the same cycle:
  - DCCM_WR_FWD_EN defined → 32'h2222_2222.
  - DCCM_WR_FWD_EN undefined → 32'h1111_1111.
  - A subsequent read returns 32'h2222_2222 in both cases.
- Range/error: a read at BASE_ADDR − 4 → rvalid_out with data 0 and an err pulse. A write at BASE_ADDR + DEPTH_WORDS*4 → err pulse, and all words are unchanged.
- Reset mid-flight: RD_LAT = 4, issue 3 reads, assert rst for 1 cycle → no rvalid_out follows and dccm_ready drops. A request during SCRUB → err pulse and no response.
